task_dispatch_stage: RTL and testbench

Upstream feeder for the per-tile conflict serializer. It takes tasks dequeued from the tile task queue and allocates a free CQ slice slot to each from an internal free list. It presents the task and slot to the serializer's enqueue port through a registered valid/ready output, and honours the serializer's almost_full back-pressure. Slots return to the free list when the commit/abort path frees them.

---
 rtl/task_dispatch_stage.sv | 181 ++++++++++++++++++
 tb/tb_task_dispatch_stage.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/task_dispatch_stage.sv
// task_dispatch_stage
// Takes tasks from the tile task queue and gives each one a free CQ slice
// slot from an internal free list. The task and its slot go to the conflict
// serializer through a registered valid/ready output. The stage respects the
// serializer's almost_full back-pressure. Slots come back through the
// free_valid/free_slot port.
//
// Ports:
//   clk, rstn                  clock, async active-low reset
//   s_valid/s_task/s_ready     task queue side (s_ready is combinational)
//   m_valid/m_task/m_cq_slot   registered output to the serializer
//   m_ready, almost_full       serializer handshake and back-pressure
//   free_valid/free_slot       slot return from commit/abort
//   slots_free                 free-list occupancy
//   init_done                  free list fully initialised
//   free_overflow              sticky: a free arrived while the list was full
//   stat_dispatched            handshakes to the serializer
//   stat_stall_cycles          RUN cycles with s_valid & !s_ready
//
// Optional feature: define DISPATCH_STATS_EN to build the two statistics
// counters. When it is undefined, both stat ports are tied to zero.
module task_dispatch_stage #(
  parameter int unsigned LOG_CQ_SIZE = 7,
  parameter int unsigned TASK_W      = 32
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   s_valid,
  input  logic [TASK_W-1:0]      s_task,
  output logic                   s_ready,
  output logic                   m_valid,
  output logic [TASK_W-1:0]      m_task,
  output logic [LOG_CQ_SIZE-1:0] m_cq_slot,
  input  logic                   m_ready,
  input  logic                   almost_full,
  input  logic                   free_valid,
  input  logic [LOG_CQ_SIZE-1:0] free_slot,
  output logic [LOG_CQ_SIZE:0]   slots_free,
  output logic                   init_done,
  output logic                   free_overflow,
  output logic [31:0]            stat_dispatched,
  output logic [31:0]            stat_stall_cycles
);

  localparam int unsigned CQ_SIZE = 2 ** LOG_CQ_SIZE;
  localparam logic [LOG_CQ_SIZE:0]   FULL = (LOG_CQ_SIZE + 1)'(CQ_SIZE);
  localparam logic [LOG_CQ_SIZE-1:0] LAST = LOG_CQ_SIZE'(CQ_SIZE - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t                 state_q, state_d;
  logic [LOG_CQ_SIZE-1:0] init_ptr_q, init_ptr_d;
  logic [LOG_CQ_SIZE-1:0] rd_ptr_q, rd_ptr_d;
  logic [LOG_CQ_SIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG_CQ_SIZE:0]   count_q, count_d;
  logic                   m_valid_q, m_valid_d;
  logic [TASK_W-1:0]      m_task_q, m_task_d;
  logic [LOG_CQ_SIZE-1:0] m_slot_q, m_slot_d;
  logic                   ovf_q, ovf_d;

  logic [LOG_CQ_SIZE-1:0] fl_mem [CQ_SIZE];
  logic                   push, pop;
  logic [LOG_CQ_SIZE-1:0] push_data;

  assign s_ready = (state_q == RUN) && (count_q != '0) && !almost_full &&
                   (!m_valid_q || m_ready);

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    m_valid_d  = m_valid_q;
    m_task_d   = m_task_q;
    m_slot_d   = m_slot_q;
    ovf_d      = ovf_q;
    push       = 1'b0;
    pop        = 1'b0;
    push_data  = free_slot;

    unique case (state_q)
      INIT: begin
        push       = 1'b1;
        push_data  = init_ptr_q;
        init_ptr_d = init_ptr_q + 1'b1;
        if (init_ptr_q == LAST) state_d = RUN;
      end
      RUN: begin
        pop = s_valid && s_ready;
        if (free_valid) begin
          // A free while full fits only if this cycle's pop opens a slot.
          // The read uses the old array contents, so writing the same
          // entry in this cycle is safe.
          if (count_q != FULL || pop) push = 1'b1;
          else                        ovf_d = 1'b1;
        end
      end
      default: state_d = INIT;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (pop) begin
      m_valid_d = 1'b1;
      m_task_d  = s_task;
      m_slot_d  = fl_mem[rd_ptr_q];
    end else if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= INIT;
      init_ptr_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      m_valid_q  <= 1'b0;
      m_task_q   <= '0;
      m_slot_q   <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      m_valid_q  <= m_valid_d;
      m_task_q   <= m_task_d;
      m_slot_q   <= m_slot_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fl_mem[wr_ptr_q] <= push_data;
  end

  assign m_valid       = m_valid_q;
  assign m_task        = m_task_q;
  assign m_cq_slot     = m_slot_q;
  assign slots_free    = count_q;
  assign init_done     = (state_q == RUN);
  assign free_overflow = ovf_q;

`ifdef DISPATCH_STATS_EN
  logic [31:0] disp_q, disp_d, stall_q, stall_d;

  always_comb begin
    disp_d  = disp_q;
    stall_d = stall_q;
    if (m_valid_q && m_ready)                    disp_d  = disp_q + 1'b1;
    if (state_q == RUN && s_valid && !s_ready)   stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      disp_q  <= '0;
      stall_q <= '0;
    end else begin
      disp_q  <= disp_d;
      stall_q <= stall_d;
    end
  end

  assign stat_dispatched   = disp_q;
  assign stat_stall_cycles = stall_q;
`else
  assign stat_dispatched   = '0;
  assign stat_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_task_dispatch_stage.sv
// Randomised and directed bench for task_dispatch_stage. It checks the DUT
// against a queue-based model of the free list and the pending output slot.
module tb_task_dispatch_stage;
  localparam int unsigned LOG = 7;
  localparam int unsigned CQ  = 128;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, s_valid, s_ready, m_valid, m_ready, almost_full;
  logic        free_valid, init_done, free_overflow;
  logic [31:0] s_task, m_task, stat_dispatched, stat_stall_cycles;
  logic [6:0]  m_cq_slot, free_slot;
  logic [7:0]  slots_free;

  task_dispatch_stage #(.LOG_CQ_SIZE(LOG), .TASK_W(32)) dut (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_task(s_task),
    .s_ready(s_ready), .m_valid(m_valid), .m_task(m_task),
    .m_cq_slot(m_cq_slot), .m_ready(m_ready), .almost_full(almost_full),
    .free_valid(free_valid), .free_slot(free_slot), .slots_free(slots_free),
    .init_done(init_done), .free_overflow(free_overflow),
    .stat_dispatched(stat_dispatched), .stat_stall_cycles(stat_stall_cycles)
  );

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  // reference model state
  bit          mr_run;
  int unsigned mr_init;
  int unsigned fq[$];
  bit          pv;
  logic [31:0] pt;
  int unsigned ps;
  bit          movf;
  int unsigned mdisp, mstall;
  bit          exp_rdy;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mr_run = 0; mr_init = 0; fq.delete(); pv = 0; pt = '0; ps = 0;
    movf = 0; mdisp = 0; mstall = 0;
  endtask

  task automatic compare();
    exp_rdy = mr_run && fq.size() != 0 && !almost_full && (!pv || m_ready);
    check("s_ready", s_ready, exp_rdy);
    check("m_valid", m_valid, pv);
    if (pv) begin
      check("m_task", m_task, pt);
      check("m_cq_slot", m_cq_slot, ps);
    end
    check("slots_free", slots_free, fq.size());
    check("init_done", init_done, mr_run);
    check("free_overflow", free_overflow, movf);
`ifdef DISPATCH_STATS_EN
    check("stat_dispatched", stat_dispatched, mdisp);
    check("stat_stall", stat_stall_cycles, mstall);
`else
    check("stat_dispatched", stat_dispatched, 0);
    check("stat_stall", stat_stall_cycles, 0);
`endif
  endtask

  // Advance the model across the coming rising edge with the current inputs.
  task automatic model_step();
    bit acc, hs;
    int unsigned sl;
    if (!mr_run) begin
      fq.push_back(mr_init);
      mr_init++;
      if (mr_init == CQ) mr_run = 1;
    end else begin
      acc = s_valid && exp_rdy;
      hs  = pv && m_ready;
      sl  = 0;
      if (hs) mdisp++;
      if (s_valid && !exp_rdy) mstall++;
      if (acc) sl = fq.pop_front();
      if (free_valid) begin
        if (fq.size() < CQ) fq.push_back(free_slot);
        else                movf = 1;
      end
      if (acc) begin pv = 1; pt = s_task; ps = sl; end
      else if (hs) pv = 0;
    end
  endtask

  // One cycle: entered and left at a falling edge.
  task automatic cyc(input bit sv, input logic [31:0] tk, input bit mrd,
                     input bit af, input bit fv, input logic [6:0] fs);
    s_valid = sv; s_task = tk; m_ready = mrd; almost_full = af;
    free_valid = fv; free_slot = fs;
    #1;
    compare();
    model_step();
    @(negedge clk);
  endtask

  initial begin
    int unsigned guard;
    rstn = 1'b0; s_valid = 0; s_task = '0; m_ready = 0; almost_full = 0;
    free_valid = 0; free_slot = '0;
    model_reset();
    #1;
    check("rst_m_task", m_task, 0);
    check("rst_m_cq_slot", m_cq_slot, 0);
    compare();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // INIT: the free list fills over exactly CQ cycles
    for (int i = 0; i < CQ; i++) cyc(0, '0, 0, 0, 0, '0);
    check("init_slots_free", slots_free, 128);
    check("init_done_up", init_done, 1);

    // three back-to-back tasks
    cyc(1, 32'hA0, 1, 0, 0, '0);
    check("bb_slot0", m_cq_slot, 0);
    cyc(1, 32'hA1, 1, 0, 0, '0);
    check("bb_slot1", m_cq_slot, 1);
    cyc(1, 32'hA2, 1, 0, 0, '0);
    check("bb_slot2", m_cq_slot, 2);
    cyc(0, '0, 1, 0, 0, '0);
    check("bb_slots_free", slots_free, 125);

    // back-pressure from m_ready, then a handshake and accept together
    cyc(1, 32'hB0, 1, 0, 0, '0);
    for (int i = 0; i < 3; i++) cyc(1, 32'hB1, 0, 0, 0, '0);
    check("hold_slot", m_cq_slot, 3);
    check("hold_task", m_task, 32'hB0);
    cyc(1, 32'hB1, 1, 0, 0, '0);
    check("swap_slot", m_cq_slot, 4);
    cyc(0, '0, 1, 0, 0, '0);

    // almost_full blocks accepts
    for (int i = 0; i < 4; i++) cyc(1, 32'hC0, 1, 1, 0, '0);

    // drain every slot, then reuse a returned slot
    guard = 0;
    while (fq.size() != 0 && guard < 300) begin
      cyc(1, $urandom, 1, 0, 0, '0);
      guard++;
    end
    check("drain_bound", guard < 300, 1);
    cyc(1, 32'hD0, 1, 0, 0, '0);
    cyc(1, 32'hD0, 1, 0, 1, 7'd5);
    cyc(1, 32'hD1, 1, 0, 0, '0);
    check("reuse_slot5", m_cq_slot, 5);

    // refill, then overflow
    for (int i = 0; i < CQ; i++) cyc(0, '0, 1, 0, 1, 7'(i));
    cyc(0, '0, 1, 0, 1, 7'd9);
    check("ovf_set", free_overflow, 1);
    for (int i = 0; i < 3; i++) cyc(0, '0, 1, 0, 0, '0);
    check("ovf_sticky", free_overflow, 1);
    check("ovf_slots_free", slots_free, 128);

    // random traffic with an asynchronous reset in the middle
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        cyc(1, $urandom, 0, 0, 0, '0);
        s_valid = 1; m_ready = 0;
        #2;
        rstn = 1'b0;
        #1;
        check("arst_m_valid", m_valid, 0);
        check("arst_s_ready", s_ready, 0);
        check("arst_init_done", init_done, 0);
        check("arst_slots_free", slots_free, 0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
      end
      cyc($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 7,
          $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 3,
          7'($urandom_range(0, CQ - 1)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
